mp_add_sched: RTL and testbench
===============================

Name: mp_add_sched

Overview:
- Multi-precision add scheduler that shares one ripple-carry slice adder (FA_7bit, WIDTH bits) between two requesters.
- Each request adds two N = WIDTH*CHUNKS bit operands with carry-in.
- The block arbitrates round-robin, latches operands and sequences the slice LSB-chunk first, carrying through a carry register.
- It returns the sum, carry-out and requester id over a valid/ready result port.
- It sits between the ALU issue logic and the shared slice adder.

Parameters:
- WIDTH, 7, bits per slice (width of the FA_7bit instance).
- CHUNKS, 4, slices per operation; N = WIDTH*CHUNKS = 28.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in0_valid  in  1  requester 0 has an operation.
- in0_ready  out  1  requester 0 accepted this cycle when in0_valid is also high.
- A0, B0  in  N each  requester 0 operands.
- cin0  in  1  requester 0 carry-in.
- in1_valid, in1_ready, A1, B1, cin1  same widths and meaning, requester 1.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- S  out  N  sum.
- cout  out  1  final carry-out.
- out_id  out  1  requester that issued the result (0 or 1).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; out_valid, S, cout, out_id = 0; in0_ready = in1_ready = 0 (combinational, and they follow state); rr_last = 1, so requester 0 wins first; chunk counter = 0; carry register = 0.
  - Reset asserted mid-operation aborts the operation. The result is discarded, and the next cycle after reset deasserts is IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - inK_ready = 1 only for the granted requester; at most one ready per cycle.
  - Grant rule: if only one valid, grant it. If both are valid, grant the requester != rr_last.
  - Acceptance happens when inK_valid & inK_ready. On acceptance: latch A, B and cin into the carry register; latch out_id = K; rr_last = K; counter = 0; go to RUN.
- RUN:
  - Each cycle, feed slice [counter] of A and B plus the carry register into FA_7bit. Write the slice sum into S bits [counter]; the carry register takes the slice cout.
  - Counter increments each cycle. After the cycle with counter = CHUNKS-1: cout = final carry, go to DONE.
  - Both readies are 0 in RUN and DONE.
- DONE:
  - out_valid = 1; S, cout and out_id are held stable while out_ready = 0.
  - On out_valid & out_ready: out_valid = 0, go to IDLE. A new request can be accepted on the cycle after the handshake, not the same cycle.
- Latency: out_valid rises CHUNKS+1 cycles after the accept edge (accept edge + CHUNKS RUN edges).
- Throughput: one operation per CHUNKS+2 cycles with out_ready held high.
- Arithmetic:
  - {cout,S} = A + B + cin, modulo 2^(N+1).
  - No signed interpretation. Overflow is reported only through cout.
- Operand changes on the input ports after acceptance have no effect, because the operands were latched.
- A request that is valid but not granted holds; its data must stay stable until accepted (standard valid/ready).
- Simultaneous valid on both requesters at every IDLE produces strict alternation.

Decomposition:
- Shared package mp_add_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the constants WIDTH_DEF=7 and CHUNKS_DEF=4;
  - the counter width function clog2(CHUNKS).
- One sub-module: the existing FA_7bit slice adder, instantiated once with width=WIDTH and driven by the chunk mux.
- Arbiter logic is small and stays inline (rr_last flop plus grant decode).

Test Plan:
- After reset, in0: A0=0x0FFFFFF, B0=0x0000001, cin0=0 → out_valid 5 cycles after accept, S=0x1000000, cout=0, out_id=0.
- in1: A1=0xFFFFFFF, B1=0x0000001, cin1=0 → S=0x0000000, cout=1, out_id=1. A second case, A1=0, B1=0, cin1=1, gives S=0x0000001, cout=0.
- Both valid in the first IDLE cycle after reset → in0 granted first (out_id=0), then in1 (out_id=1). With both valid continuously for 4 operations, the ids are 0,1,0,1.
- out_ready held low for 10 cycles in DONE → out_valid stays 1; S, cout and out_id stay stable; in0_ready = in1_ready = 0 throughout. Release → IDLE next cycle.
- rst pulsed for 1 cycle while RUN has counter=2 → next cycle IDLE, out_valid=0, S=0, and no result emitted. A fresh request completes correctly with rr_last reset, so in0 is favoured.
- Random A, B, cin (1000 operations, random valid/ready gaps) → scoreboard matches A+B+cin and the id order per the round-robin model.

Source files
------------

// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared types and constants for the multi-precision add scheduler.
//   state_t     - scheduler FSM states (IDLE, RUN, DONE)
//   WIDTH_DEF   - default slice width (bits per FA_7bit pass)
//   CHUNKS_DEF  - default number of slices per operation
//   clog2()     - chunk-counter width, never less than 1 bit
package mp_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF  = 7;
    localparam int CHUNKS_DEF = 4;

    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mp_add_sched_if.sv
// mp_add_sched_if: request/result bundle between the ALU issue logic,
// the result consumer and mp_add_sched.
//   in0_* / in1_*    - requester valid/ready handshake, operands A/B, carry-in
//   out_*            - result valid/ready handshake, sum S, carry-out, requester id
//   modport master   - the requester/consumer side
//   modport slave    - the scheduler side
interface mp_add_sched_if #(
    parameter int N = mp_add_pkg::WIDTH_DEF * mp_add_pkg::CHUNKS_DEF
) ();

    logic         in0_valid;
    logic         in0_ready;
    logic [N-1:0] A0;
    logic [N-1:0] B0;
    logic         cin0;

    logic         in1_valid;
    logic         in1_ready;
    logic [N-1:0] A1;
    logic [N-1:0] B1;
    logic         cin1;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] S;
    logic         cout;
    logic         out_id;

    modport master (
        output in0_valid, A0, B0, cin0,
        output in1_valid, A1, B1, cin1,
        output out_ready,
        input  in0_ready, in1_ready,
        input  out_valid, S, cout, out_id
    );

    modport slave (
        input  in0_valid, A0, B0, cin0,
        input  in1_valid, A1, B1, cin1,
        input  out_ready,
        output in0_ready, in1_ready,
        output out_valid, S, cout, out_id
    );

endinterface

// File: rtl/FA_7bit.sv
// FA_7bit: ripple-carry slice adder shared by the scheduler.
//   a, b  - slice operands (width bits)
//   cin   - carry into the slice
//   s     - slice sum
//   cout  - carry out of the slice
module FA_7bit #(
    parameter int width = 7
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, cin};

endmodule

// File: rtl/mp_add_sched.sv
// mp_add_sched: shares one FA_7bit slice between two requesters to perform
// N = WIDTH*CHUNKS bit adds with carry-in. Round-robin arbitration, operands
// latched on accept, slices processed LSB first through a carry register,
// result returned over a valid/ready port.
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset (aborts any operation in flight)
//   bus  - mp_add_sched_if.slave: two request ports and the result port
module mp_add_sched
    import mp_add_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int CHUNKS = CHUNKS_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mp_add_sched_if.slave bus
);

    localparam int              N    = WIDTH * CHUNKS;
    localparam int              CW   = clog2(CHUNKS);
    localparam logic [CW-1:0]   LAST = CW'(CHUNKS - 1);

    state_t          state;
    logic            rr_last;     // requester granted most recently
    logic [CW-1:0]   cnt;         // slice being processed in RUN
    logic            carry;
    logic [N-1:0]    a_r;
    logic [N-1:0]    b_r;
    logic [N-1:0]    s_r;
    logic            cout_r;
    logic            out_id_r;
    logic            out_valid_r;

    logic            g0;
    logic            g1;
    logic [WIDTH-1:0] sl_a;
    logic [WIDTH-1:0] sl_b;
    logic [WIDTH-1:0] sl_s;
    logic             sl_co;

    // A lone requester always wins; on a tie the one not served last wins.
    assign g0 = bus.in0_valid & (~bus.in1_valid | rr_last);
    assign g1 = bus.in1_valid & (~bus.in0_valid | ~rr_last);

    assign bus.in0_ready = (state == IDLE) & g0;
    assign bus.in1_ready = (state == IDLE) & g1;

    assign bus.out_valid = out_valid_r;
    assign bus.S         = s_r;
    assign bus.cout      = cout_r;
    assign bus.out_id    = out_id_r;

    // chunk mux feeding the shared slice
    assign sl_a = WIDTH'(a_r >> (int'(cnt) * WIDTH));
    assign sl_b = WIDTH'(b_r >> (int'(cnt) * WIDTH));

    FA_7bit #(.width(WIDTH)) u_fa (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .s    (sl_s),
        .cout (sl_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_last     <= 1'b1;
            cnt         <= '0;
            carry       <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            s_r         <= '0;
            cout_r      <= 1'b0;
            out_id_r    <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // g0/g1 are one-hot when set, so g1 alone selects the winner
                    if (g0 | g1) begin
                        a_r      <= g1 ? bus.A1 : bus.A0;
                        b_r      <= g1 ? bus.B1 : bus.B0;
                        carry    <= g1 ? bus.cin1 : bus.cin0;
                        out_id_r <= g1;
                        rr_last  <= g1;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    s_r[int'(cnt)*WIDTH +: WIDTH] <= sl_s;
                    carry <= sl_co;
                    if (cnt == LAST) begin
                        cout_r      <= sl_co;
                        out_valid_r <= 1'b1;
                        cnt         <= '0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_sched.sv
// tb_mp_add_sched: self-checking bench for mp_add_sched. Expected results are
// queued when a request is accepted and compared when the result handshakes.
module tb_mp_add_sched;
    import mp_add_pkg::*;

    localparam int WIDTH  = WIDTH_DEF;
    localparam int CHUNKS = CHUNKS_DEF;
    localparam int N      = WIDTH * CHUNKS;
    localparam int NOPS   = 1000;

    typedef struct packed {
        logic [N-1:0] s;
        logic         c;
        logic         id;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mp_add_sched_if #(.N(N)) bus ();

    mp_add_sched #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    res_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic c, input logic id);
        logic [N:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
        return '{s: sum[N-1:0], c: sum[N], id: id};
    endfunction

    function automatic res_t dut_res();
        return '{s: bus.S, c: bus.cout, id: bus.out_id};
    endfunction

    function automatic logic [N-1:0] rnd_op();
        if ($urandom_range(0, 7) == 0) return '1;
        return N'($urandom);
    endfunction

    task automatic drive(input logic k, input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        if (k) begin bus.A1 = a; bus.B1 = b; bus.cin1 = c; bus.in1_valid = 1'b1; end
        else   begin bus.A0 = a; bus.B0 = b; bus.cin0 = c; bus.in0_valid = 1'b1; end
    endtask

    // drop valid and scramble the operands so latching is exercised
    task automatic drop(input logic k);
        if (k) begin bus.in1_valid = 1'b0; bus.A1 = N'($urandom); bus.B1 = N'($urandom); bus.cin1 = 1'($urandom); end
        else   begin bus.in0_valid = 1'b0; bus.A0 = N'($urandom); bus.B0 = N'($urandom); bus.cin0 = 1'($urandom); end
    endtask

    // call after a negedge; returns 1ns after the accepting posedge
    task automatic send(input logic k, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic c, output bit ok);
        bit acc;
        acc = 1'b0;
        drive(k, a, b, c);
        for (int t = 0; t < 50 && !acc; t++) begin
            #1;
            acc = k ? bus.in1_ready : bus.in0_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        #1;
        drop(k);
        ok = acc;
    endtask

    // counts posedges until out_valid is seen (sampled 1ns after each edge)
    task automatic wait_valid(output int lat, output bit got);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        got = bus.out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.S, bus.cout, bus.out_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b S=%h cout=%b id=%b, want all 0",
                     bus.out_valid, bus.S, bus.cout, bus.out_id);
        end
        n_checks++;
        if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b%b want 00", bus.in0_ready, bus.in1_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic         tk [3];
        logic [N-1:0] ta [3];
        logic [N-1:0] tbv[3];
        logic         tc [3];
        res_t         te [3];
        res_t         exp;
        int           lat;
        bit           ok, got;
        tk  = '{1'b0, 1'b1, 1'b1};
        ta  = '{28'h0FFFFFF, 28'hFFFFFFF, 28'h0000000};
        tbv = '{28'h0000001, 28'h0000001, 28'h0000000};
        tc  = '{1'b0, 1'b0, 1'b1};
        te  = '{'{28'h1000000, 1'b0, 1'b0}, '{28'h0000000, 1'b1, 1'b1}, '{28'h0000001, 1'b0, 1'b1}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sbq.push_back(te[i]);
            send(tk[i], ta[i], tbv[i], tc[i], ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL basic_accept[%0d]: request not accepted", i); end
            wait_valid(lat, got);
            n_checks++;
            if (lat !== CHUNKS) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: got %0d edges after accept, want %0d", i, lat, CHUNKS);
            end
            exp = sbq.pop_front();
            n_checks++;
            if (dut_res() !== exp) begin
                n_fail++;
                $display("FAIL basic_result[%0d]: got S=%h c=%b id=%b want S=%h c=%b id=%b",
                         i, bus.S, bus.cout, bus.out_id, exp.s, exp.c, exp.id);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_release[%0d]: out_valid got %b want 0", i, bus.out_valid);
            end
        end
    endtask

    // both requesters valid continuously from the first IDLE cycle after reset
    task automatic test_arb();
        int   accepted, received, cyc, last_acc;
        logic exp_id;
        logic acc0, acc1;
        res_t exp;
        accepted = 0; received = 0; cyc = 0; last_acc = -1; exp_id = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, rnd_op(), rnd_op(), 1'($urandom));
        drive(1'b1, rnd_op(), rnd_op(), 1'($urandom));
        bus.out_ready = 1'b1;
        while (received < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) begin
                exp = sbq.pop_front();
                n_checks++;
                if (dut_res() !== exp) begin
                    n_fail++;
                    $display("FAIL arb_result[%0d]: got S=%h c=%b id=%b want S=%h c=%b id=%b",
                             received, bus.S, bus.cout, bus.out_id, exp.s, exp.c, exp.id);
                end
                received++;
            end
            acc0 = bus.in0_valid & bus.in0_ready;
            acc1 = bus.in1_valid & bus.in1_ready;
            if (acc0 | acc1) begin
                n_checks++;
                if ({acc1, acc0} !== (exp_id ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL arb_grant[%0d]: got grant %b%b want id %b", accepted, acc1, acc0, exp_id);
                end
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc !== CHUNKS + 2) begin
                        n_fail++;
                        $display("FAIL arb_spacing[%0d]: got %0d cycles want %0d", accepted, cyc - last_acc, CHUNKS + 2);
                    end
                end
                if (acc1) sbq.push_back(model(bus.A1, bus.B1, bus.cin1, 1'b1));
                else      sbq.push_back(model(bus.A0, bus.B0, bus.cin0, 1'b0));
                last_acc = cyc;
                exp_id   = ~exp_id;
                accepted++;
            end
            @(posedge clk); #1;
            if (accepted >= 4) begin
                drop(1'b0); drop(1'b1);
            end else if (acc0) drive(1'b0, rnd_op(), rnd_op(), 1'($urandom));
            else if (acc1) drive(1'b1, rnd_op(), rnd_op(), 1'($urandom));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (received !== 4) begin
            n_fail++;
            $display("FAIL arb_timeout: got %0d results want 4", received);
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] a, b;
        logic         c;
        res_t         exp;
        int           lat;
        bit           ok, got;
        a = rnd_op(); b = rnd_op(); c = 1'($urandom);
        @(negedge clk);
        sbq.push_back(model(a, b, c, 1'b0));
        send(1'b0, a, b, c, ok);
        wait_valid(lat, got);
        exp = sbq.pop_front();
        bus.in0_valid = 1'b1;
        bus.in1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.out_valid, dut_res()} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b S=%h c=%b id=%b want v=1 S=%h c=%b id=%b",
                         i, bus.out_valid, bus.S, bus.cout, bus.out_id, exp.s, exp.c, exp.id);
            end
            n_checks++;
            if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: got %b%b want 00", i, bus.in0_ready, bus.in1_ready);
            end
        end
        @(negedge clk);
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: out_valid got %b want 0", bus.out_valid);
        end
        bus.in0_valid = 1'b1;
        #1;
        n_checks++;
        if (bus.in0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_idle: in0_ready got %b want 1", bus.in0_ready);
        end
        bus.in0_valid = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [N-1:0] a, b;
        res_t         exp;
        int           lat;
        bit           ok, got;
        @(negedge clk);
        send(1'b1, rnd_op(), rnd_op(), 1'b1, ok);
        // RUN with counter 0 now; two more edges bring it to 2
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.S} !== '0) begin
            n_fail++;
            $display("FAIL abort_clear: got v=%b S=%h want v=0 S=0", bus.out_valid, bus.S);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_result[%0d]: out_valid got %b want 0", i, bus.out_valid);
            end
        end
        a = rnd_op(); b = rnd_op();
        @(negedge clk);
        drive(1'b0, a, b, 1'b0);
        drive(1'b1, rnd_op(), rnd_op(), 1'b0);
        #1;
        n_checks++;
        if ({bus.in1_ready, bus.in0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_rr: got ready %b%b want 01", bus.in1_ready, bus.in0_ready);
        end
        bus.in1_valid = 1'b0;
        sbq.push_back(model(a, b, 1'b0, 1'b0));
        send(1'b0, a, b, 1'b0, ok);
        wait_valid(lat, got);
        exp = sbq.pop_front();
        n_checks++;
        if (dut_res() !== exp || !got) begin
            n_fail++;
            $display("FAIL abort_fresh: got v=%b S=%h c=%b id=%b want S=%h c=%b id=%b",
                     got, bus.S, bus.cout, bus.out_id, exp.s, exp.c, exp.id);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        int   issued, accepted, received, dcyc, ccyc;
        logic rr, acc0, acc1, k;
        res_t exp;
        issued = 0; accepted = 0; received = 0; dcyc = 0; ccyc = 0; rr = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fork
            begin
                while (accepted < NOPS && dcyc < 60000) begin
                    @(negedge clk);
                    dcyc++;
                    acc0 = bus.in0_valid & bus.in0_ready;
                    acc1 = bus.in1_valid & bus.in1_ready;
                    if (acc0 | acc1) begin
                        k = acc1;
                        n_checks++;
                        if ((acc0 & acc1) || (bus.in0_valid && bus.in1_valid && k == rr)) begin
                            n_fail++;
                            $display("FAIL rand_arb[%0d]: got grant %b%b with valid %b%b want id !%b",
                                     accepted, acc1, acc0, bus.in1_valid, bus.in0_valid, rr);
                        end
                        rr = k;
                        if (k) sbq.push_back(model(bus.A1, bus.B1, bus.cin1, 1'b1));
                        else   sbq.push_back(model(bus.A0, bus.B0, bus.cin0, 1'b0));
                        accepted++;
                    end
                    @(posedge clk); #1;
                    if (acc0) bus.in0_valid = 1'b0;
                    if (acc1) bus.in1_valid = 1'b0;
                    if (!bus.in0_valid && issued < NOPS && $urandom_range(0, 1) == 1) begin
                        drive(1'b0, rnd_op(), rnd_op(), 1'($urandom));
                        issued++;
                    end
                    if (!bus.in1_valid && issued < NOPS && $urandom_range(0, 1) == 1) begin
                        drive(1'b1, rnd_op(), rnd_op(), 1'($urandom));
                        issued++;
                    end
                end
            end
            begin
                while (received < NOPS && ccyc < 60000) begin
                    @(negedge clk);
                    ccyc++;
                    if (bus.out_valid && bus.out_ready) begin
                        n_checks++;
                        if (sbq.size() == 0) begin
                            n_fail++;
                            $display("FAIL rand_unexpected: got S=%h id=%b with empty scoreboard", bus.S, bus.out_id);
                        end else begin
                            exp = sbq.pop_front();
                            if (dut_res() !== exp) begin
                                n_fail++;
                                $display("FAIL rand_result[%0d]: got S=%h c=%b id=%b want S=%h c=%b id=%b",
                                         received, bus.S, bus.cout, bus.out_id, exp.s, exp.c, exp.id);
                            end
                        end
                        received++;
                    end
                    if (received < NOPS) begin
                        @(posedge clk); #1;
                        bus.out_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            end
        join
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (received !== NOPS || sbq.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: got %0d results (%0d pending) want %0d", received, sbq.size(), NOPS);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in0_valid = 1'b0; bus.A0 = '0; bus.B0 = '0; bus.cin0 = 1'b0;
        bus.in1_valid = 1'b0; bus.A1 = '0; bus.B1 = '0; bus.cin1 = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_arb();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
